joy_db15_tx: RTL
================

JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 clk_sys  input  1  system clock (48 MHz); sole clock of the block.
REQ-002 reset_n  input  1  asynchronous, active-low reset; deassertion synchronised to clk_sys internally.
REQ-003 joystick1  input  12  player-1 state, active-high: [0] right, [1] left, [2] down, [3] up, [11:4] buttons 1-8.
REQ-004 joystick2  input  12  player-2 state, same bit layout as joystick1.
REQ-005 JOY_LOAD  input  1  parallel-load strobe from the DB15 reader, asynchronous to clk_sys; low = load.
REQ-006 JOY_CLK  input  1  shift clock from the reader, asynchronous to clk_sys; rising edge = shift.
REQ-007 JOY_DATA  output  1  serial data to the reader, active-low (0 = pressed).
REQ-008 frame_done  output  1  one-cycle pulse when the last frame bit has been shifted out.
REQ-009 state_o  output  2  current FSM state, for debug.
REQ-010 Parameter FRAME_BITS, default 24, frame length; fixed at 2 x PLAYER_BITS.
REQ-011 Parameter PLAYER_BITS, default 12, bits per player.

Function
REQ-012 JOY_LOAD and JOY_CLK each pass through a 2-flop synchroniser with reset value 1; all logic uses only the synchronised copies.
REQ-013 JOY_CLK rising edge detected as sync=1 and previous sync=0 (one-cycle event).
REQ-014 Shift register sr[23:0]; JOY_DATA = sr[0] at all times.
REQ-015 While synchronised JOY_LOAD = 0: every cycle, sr <= ~{joystick2, joystick1}; bit counter <= 0; edges on JOY_CLK ignored (transparent load).
REQ-016 While synchronised JOY_LOAD = 1 and a JOY_CLK edge is detected: sr <= {1'b1, sr[23:1]}; counter increments.
REQ-017 Frame order on JOY_DATA: p1[0] .. p1[11], then p2[0] .. p2[11]; bit 0 is valid before the first shift.
REQ-018 Counter saturates at FRAME_BITS; further shifts continue inserting 1, so JOY_DATA = 1 beyond the frame.
REQ-019 frame_done pulses for one cycle in the cycle after the counter goes 23 -> 24; it never pulses on saturated shifts.
REQ-020 Latency: JOY_DATA changes exactly 3 clk_sys cycles after a JOY_CLK rising edge at the pin (2 sync + 1 register).
REQ-021 Load has priority over a simultaneous JOY_CLK edge.
REQ-022 A load asserted mid-frame aborts the frame: counter is cleared and frame_done is not pulsed.
REQ-023 FSM states IDLE=0, LOAD=1, SHIFT=2, DONE=3.
REQ-024 IDLE -> LOAD on JOY_LOAD low.
REQ-025 LOAD -> SHIFT on JOY_LOAD high.
REQ-026 SHIFT -> DONE on counter reaching 24.
REQ-027 SHIFT or DONE -> LOAD on JOY_LOAD low.
REQ-028 DONE holds until the next load.
REQ-029 Inputs joystick1/2 are sampled only during LOAD; changes during SHIFT do not affect the frame in flight.

Reset
REQ-030 On reset_n low, asynchronously: sr = all ones, JOY_DATA = 1, counter = 0, frame_done = 0, state = IDLE, synchronisers = 1.
REQ-031 Reset asserted mid-frame discards the frame; after release, no shift takes effect until a new load.

Structure
REQ-032 Package db15_pkg holds FRAME_BITS, PLAYER_BITS, SYNC_STAGES=2, the FSM state enum, and the joystick bit-index constants.
REQ-033 One sub-module, db15_sync: parameterised N-flop synchroniser with a reset value input, instantiated twice.
REQ-034 No other hierarchy; the shift register, counter and FSM live in joy_db15_tx.

Verification
REQ-035 Reset: reset_n low with JOY_CLK toggling -> JOY_DATA=1, frame_done=0, state_o=0 throughout.
REQ-036 Full frame: joystick1=12'h009, joystick2=12'h800, load pulse, then 24 JOY_CLK edges.
  -> JOY_DATA sequence is 0,1,1,0, then eight 1s, then eleven 1s, then 0.
  -> frame_done pulses once, 1 cycle after the 24th edge registers; state_o=3.
REQ-037 Overrun: 30 JOY_CLK edges after load with joystick1=12'hFFF -> bits 0-11 = 0, bits 12-29 = 1, exactly one frame_done.
REQ-038 Mid-frame reload: load, 10 edges, then JOY_LOAD low with joystick1 changed to 12'h001.
  -> counter = 0, no frame_done, JOY_DATA = 0 within 3 cycles.
REQ-039 Priority/latency: JOY_CLK edge coincident with JOY_LOAD low -> no shift. Isolated edge -> JOY_DATA updates on cycle 3, not 2 or 4.
REQ-040 Input stability: joystick2 changed from 12'h000 to 12'hFFF during SHIFT -> p2 bits of the current frame stay 1; the change appears after the next load.

Source files
------------

// File: rtl/db15_pkg.sv
// Shared constants and types for the DB15 joystick serialiser.
package db15_pkg;

   localparam int PLAYER_BITS = 12;
   localparam int FRAME_BITS  = 2 * PLAYER_BITS;
   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } db15_state_t;

   // Bit positions inside a player's 12-bit joystick word
   localparam int JOY_RIGHT = 0;
   localparam int JOY_LEFT  = 1;
   localparam int JOY_DOWN  = 2;
   localparam int JOY_UP    = 3;
   localparam int JOY_BTN1  = 4;
   localparam int JOY_BTN8  = 11;

endpackage

// File: rtl/db15_sync.sv
// N-flop synchroniser for a single asynchronous level; resets to rst_val.
module db15_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic rst_val,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff_p0;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         ff_p0 <= {STAGES{rst_val}};
      end else begin
         ff_p0 <= {ff_p0[STAGES-2:0], d};
      end
   end

   assign q = ff_p0[STAGES-1];

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick transmitter: loads both players on JOY_LOAD low and shifts
// the active-low frame out on JOY_DATA, one bit per JOY_CLK rising edge.
module joy_db15_tx #(
   parameter int PLAYER_BITS = db15_pkg::PLAYER_BITS,
   parameter int FRAME_BITS  = 2 * PLAYER_BITS
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic [PLAYER_BITS-1:0] joystick1,
   input  logic [PLAYER_BITS-1:0] joystick2,
   input  logic                   JOY_LOAD,
   input  logic                   JOY_CLK,
   output logic                   JOY_DATA,
   output logic                   frame_done,
   output logic [1:0]             state_o
);
   import db15_pkg::*;

   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

   logic [1:0]            rst_sync_p0;
   logic                  rst_int_n;
   logic                  load_s;
   logic                  jclk_s;
   logic                  jclk_d;
   logic                  clk_rise;
   logic                  shift_en;
   logic [FRAME_BITS-1:0] sr;
   logic [CNT_W-1:0]      cnt;
   db15_state_t           state;

   // Reset asserts immediately, releases two clk_sys edges later
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_p0 <= 2'b00;
      end else begin
         rst_sync_p0 <= {rst_sync_p0[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_p0[1];

   db15_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
      .clk_sys (clk_sys),
      .reset_n (rst_int_n),
      .rst_val (1'b1),
      .d       (JOY_LOAD),
      .q       (load_s)
   );

   db15_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .clk_sys (clk_sys),
      .reset_n (rst_int_n),
      .rst_val (1'b1),
      .d       (JOY_CLK),
      .q       (jclk_s)
   );

   assign clk_rise = jclk_s & ~jclk_d;
   // IDLE blocks shifting so a frame cut short by reset cannot resume
   assign shift_en = load_s & clk_rise & (state != ST_IDLE);

   always_ff @(posedge clk_sys or negedge rst_int_n) begin
      if (!rst_int_n) begin
         jclk_d     <= 1'b1;
         sr         <= '1;
         cnt        <= '0;
         frame_done <= 1'b0;
         state      <= ST_IDLE;
      end else begin
         jclk_d     <= jclk_s;
         frame_done <= 1'b0;
         if (!load_s) begin
            sr    <= ~{joystick2, joystick1};
            cnt   <= '0;
            state <= ST_LOAD;
         end else begin
            if (shift_en) begin
               sr <= {1'b1, sr[FRAME_BITS-1:1]};
               if (cnt != CNT_FULL) begin
                  cnt <= cnt + 1'b1;
               end
               if (cnt == CNT_LAST) begin
                  frame_done <= 1'b1;
               end
            end
            case (state)
               ST_LOAD:  state <= ST_SHIFT;
               ST_SHIFT: if (cnt == CNT_FULL) state <= ST_DONE;
               default:  state <= state;
            endcase
         end
      end
   end

   assign JOY_DATA = sr[0];
   assign state_o  = state;

endmodule
